memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1048576, meaning size of the byte-addressed storage (valid byte addresses 0..MEM_BYTES-1).
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, request valid when high.
REQ-006 SHALL have port rd_wr, input, 1, transfer direction: 1 = read, 0 = write.
REQ-007 SHALL have port access_size, input, 2, burst length code: 0 = 1 word, 1 = 4 words, 2 = 8 words, 3 = 16 words.
REQ-008 SHALL have port addr, input, 32, byte start address; bits [1:0] are ignored (word aligned).
REQ-009 SHALL have port data_in, input, 32, write data for the current beat.
REQ-010 SHALL have port data_out, output, 32, registered read data.
REQ-011 SHALL have port busy, output, 1, high while a multi-beat burst has remaining beats.

Function
REQ-012 Storage SHALL be MEM_BYTES/4 words; word index = addr[31:2].
REQ-013 Request acceptance SHALL occur on a rising edge with enable=1 and busy=0; the edge latches rd_wr, access_size and addr, and executes beat 0.
REQ-014 Beat k SHALL access word address addr + 4*k; beats issue on consecutive cycles with no gaps.
REQ-015 Write beat SHALL store data_in sampled at that beat's edge; the software drives a new data_in word every cycle.
REQ-016 Read beat SHALL update data_out at that beat's edge; the value is visible one cycle after the request is presented.
REQ-017 busy SHALL rise on the acceptance edge when the burst length > 1 and fall on the edge executing the last beat; busy SHALL stay 0 for single-word accesses.
REQ-018 While busy=1, enable, rd_wr, access_size and addr SHALL be ignored; a started burst completes even if enable drops.
REQ-019 A beat whose byte address is >= MEM_BYTES SHALL be out of range: the write is dropped; the read sets data_out = 0. Addresses SHALL NOT wrap.
REQ-020 With enable=0 and busy=0, memory and data_out SHALL hold.
REQ-021 Back-to-back single accesses SHALL be supported every cycle; a read on the cycle after a write to the same word SHALL return the new value.

Reset
REQ-022 rst_n=0 SHALL immediately clear data_out to 0 and busy to 0 and abort any burst; storage contents are not cleared.
REQ-023 The first request SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-024 Package memory_pkg SHALL hold the access_size enum (SZ_1, SZ_4, SZ_8, SZ_16), the beat-count function, and the default MEM_BYTES constant.
REQ-025 Sub-module memory_burst_ctrl SHALL hold the beat counter, the latched address/direction, and busy; memory holds the storage array and the range check.

Verification
REQ-026 Write 234 @0, then read @0 -> data_out=234 one cycle later, busy=0 throughout.
REQ-027 Write 1537628013 @4, 537628013 @8, 2537628013 @12; read burst size 1 @0 -> data_out over 4 cycles = 234, 1537628013, 537628013, 2537628013; busy high for 3 cycles.
REQ-028 Drop enable two cycles into the 4-beat burst -> the remaining beats still occur; afterwards data_out holds 2537628013.
REQ-029 Write 10448573 @1048572, then read -> 10448573; write 910448573 @1048576, then read -> 0, and word @1048572 is unchanged.
REQ-030 Assert rst_n=0 mid-burst -> data_out=0 and busy=0 asynchronously; after release, a read @0 -> 234.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and helpers for the burst-capable word memory.
package memory_pkg;

    localparam int MEM_BYTES_DEF = 1048576;

    typedef enum logic [1:0] {
        SZ_1  = 2'd0,
        SZ_4  = 2'd1,
        SZ_8  = 2'd2,
        SZ_16 = 2'd3
    } size_e;

    function automatic logic [4:0] beat_count(size_e sz);
        logic [4:0] n;
        unique case (sz)
            SZ_1:    n = 5'd1;
            SZ_4:    n = 5'd4;
            SZ_8:    n = 5'd8;
            SZ_16:   n = 5'd16;
            default: n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/memory_burst_ctrl.sv
// Burst sequencer: beat 0 runs off the live request, later beats
// off the latched direction and a running 33-bit (non-wrapping) address.
module memory_burst_ctrl
    import memory_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rd_wr,
    input  logic [1:0]  access_size,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        beat_go,
    output logic        beat_rd,
    output logic [32:0] beat_addr
);

    logic        rd_q;
    logic [32:0] addr_q;
    logic [4:0]  remain;
    logic        accept;
    logic [4:0]  n_beats;
    logic [32:0] base;

    always_comb begin
        accept    = enable && !busy;
        base      = {1'b0, addr & 32'hFFFF_FFFC};
        n_beats   = beat_count(size_e'(access_size));
        beat_go   = accept || busy;
        beat_rd   = busy ? rd_q : rd_wr;
        beat_addr = busy ? addr_q : base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= '0;
            remain <= '0;
        end else if (accept) begin
            busy   <= (n_beats != 5'd1);
            rd_q   <= rd_wr;
            addr_q <= base + 33'd4;
            remain <= n_beats - 5'd1;
        end else if (busy) begin
            addr_q <= addr_q + 33'd4;
            remain <= remain - 5'd1;
            if (remain == 5'd1)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/memory.sv
// Word-organised byte-addressed memory with 1/4/8/16-beat bursts.
// Beats past the top of storage drop writes and read as zero.
module memory
    import memory_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rd_wr,
    input  logic [1:0]        access_size,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IW    = $clog2(WORDS);

    logic [DATA_W-1:0] mem [WORDS];
    logic              beat_go;
    logic              beat_rd;
    logic [32:0]       beat_addr;
    logic              in_range;
    logic [IW-1:0]     idx;

    memory_burst_ctrl u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rd_wr       (rd_wr),
        .access_size (access_size),
        .addr        (addr),
        .busy        (busy),
        .beat_go     (beat_go),
        .beat_rd     (beat_rd),
        .beat_addr   (beat_addr)
    );

    always_comb begin
        in_range = beat_addr < 33'(MEM_BYTES);
        idx      = IW'(beat_addr >> 2);
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && beat_go && !beat_rd && in_range)
            mem[idx] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_out <= '0;
        else if (beat_go && beat_rd)
            data_out <= in_range ? mem[idx] : '0;
    end

endmodule

// File: tb/tb_memory.sv
// Randomised bench for memory against a beat-queue reference model.
module tb_memory;

    localparam longint MEMB = 1048576;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable = 1'b0;
    logic        rd_wr = 1'b0;
    logic [1:0]  access_size = 2'd0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rd_wr       (rd_wr),
        .access_size (access_size),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     rd;
        longint a;
    } beat_t;

    beat_t       q[$];
    logic [31:0] mref [longint];
    logic [31:0] exp_do = '0;
    logic        exp_busy = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference: each accepted request becomes a list of pending beats,
    // one beat retired per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_do   = '0;
            exp_busy = 1'b0;
        end else begin
            if (q.size() == 0 && enable) begin
                int     n;
                longint a0;
                n  = (access_size == 2'd0) ? 1 : (4 << (access_size - 1));
                a0 = 0;
                a0[31:0] = {addr[31:2], 2'b00};
                for (int k = 0; k < n; k++)
                    q.push_back('{rd_wr, a0 + 4 * k});
            end
            if (q.size() > 0) begin
                beat_t b;
                b = q.pop_front();
                if (b.rd)
                    exp_do = (b.a < MEMB) ? mref[b.a >> 2] : 32'd0;
                else if (b.a < MEMB)
                    mref[b.a >> 2] = data_in;
            end
            exp_busy = (q.size() > 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("model_data_out", data_out, exp_do);
            chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
        end
    end

    task automatic cyc(bit en, bit rd, logic [1:0] sz,
                       logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        enable      = en;
        rd_wr       = rd;
        access_size = sz;
        addr        = a;
        data_in     = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    logic [31:0] burst_exp [4];

    initial begin
        burst_exp[0] = 32'd234;
        burst_exp[1] = 32'd1537628013;
        burst_exp[2] = 32'd537628013;
        burst_exp[3] = 32'd2537628013;

        rst_n = 1'b0;
        #1;
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1, 0, 2'd0, 32'd0, 32'd234);
        cyc(1, 1, 2'd0, 32'd0, 32'd0);
        idle();
        chk("rd_after_wr", data_out, 32'd234);
        chk("single_busy", {31'd0, busy}, 32'd0);

        cyc(1, 0, 2'd0, 32'd4, 32'd1537628013);
        cyc(1, 0, 2'd0, 32'd8, 32'd537628013);
        cyc(1, 0, 2'd0, 32'd12, 32'd2537628013);
        cyc(1, 1, 2'd1, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("burst4_data", data_out, burst_exp[k]);
            chk("burst4_busy", {31'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
        end

        cyc(1, 1, 2'd1, 32'd0, 32'd0);
        cyc(1, 0, 2'd0, 32'd100, 32'd999);
        idle();
        idle();
        idle();
        chk("drop_en_data", data_out, 32'd2537628013);
        chk("drop_en_busy", {31'd0, busy}, 32'd0);

        cyc(1, 0, 2'd0, 32'd1048572, 32'd10448573);
        cyc(1, 1, 2'd0, 32'd1048572, 32'd0);
        idle();
        chk("top_word", data_out, 32'd10448573);
        cyc(1, 0, 2'd0, 32'd1048576, 32'd910448573);
        cyc(1, 1, 2'd0, 32'd1048576, 32'd0);
        idle();
        chk("oor_read", data_out, 32'd0);
        cyc(1, 1, 2'd0, 32'd1048572, 32'd0);
        idle();
        chk("top_unchanged", data_out, 32'd10448573);

        cyc(1, 1, 2'd1, 32'd0, 32'd0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", data_out, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 2'd0, 32'd0, 32'd0);
        idle();
        chk("post_rst_read", data_out, 32'd234);

        for (int w = 0; w < 64; w++)
            cyc(1, 0, 2'd0, 32'(w * 4), $urandom);
        for (int w = 0; w < 64; w++)
            cyc(1, 0, 2'd0, 32'(MEMB - 256 + w * 4), $urandom);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = 32'($urandom_range(0, 48) * 4 + $urandom_range(0, 3));
                1: a = 32'(MEMB - 256 + $urandom_range(0, 63) * 4);
                2: a = 32'(MEMB + $urandom_range(0, 15) * 4);
                default: a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4);
            endcase
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), a, $urandom);
        end
        for (int i = 0; i < 20; i++)
            idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
